// File: rtl/simmem_pkg.sv
// Shared types and default geometry for the simmem message bank.
// Slot pointers index the shared RAM; credits count release grants.
package simmem_pkg;

  localparam int DefStructWidth = 64;
  localparam int DefIdWidth = 4;
  localparam int DefCapacity = 32;
  localparam int DefMaxCredit = DefCapacity;

  typedef logic [$clog2(DefCapacity)-1:0] slot_ptr_t;
  typedef logic [$clog2(DefMaxCredit+1)-1:0] credit_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Round-robin pick among requesting IDs, searching from the
// ID after last_id and wrapping; grant is gated by advance.
module simmem_rr_arbiter #(
  parameter int NumIds = 16,
  localparam int IdW = $clog2(NumIds)
) (
  input  logic [NumIds-1:0] req,
  input  logic [IdW-1:0]    last_id,
  input  logic              advance,
  output logic [NumIds-1:0] grant,
  output logic [IdW-1:0]    grant_id
);

  logic           found;
  logic [IdW-1:0] idx;

  // first requester after last_id wins; k=NumIds wraps to last_id
  always_comb begin
    grant = '0;
    grant_id = last_id;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NumIds; k++) begin
      idx = last_id + IdW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant_id = idx;
      end
    end
    if (advance && found) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/simmem_id_message_bank.sv
// Shared-RAM message bank: one linked-list FIFO per ID, released
// by credits. Optional SIMMEM_MSG_BANK_OCCUPANCY_EN adds occupancy ports.
module simmem_id_message_bank
  import simmem_pkg::*;
#(
  parameter int StructWidth = DefStructWidth,
  parameter int IdWidth = DefIdWidth,
  parameter int Capacity = DefCapacity,
  parameter int MaxCredit = Capacity
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [StructWidth-1:0] data_i,
  input  logic                   release_valid_i,
  input  logic [IdWidth-1:0]     release_id_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [StructWidth-1:0] data_o
`ifdef SIMMEM_MSG_BANK_OCCUPANCY_EN
  ,
  output logic [$clog2(Capacity+1)-1:0] free_slots_o,
  output logic [2**IdWidth-1:0]         id_nonempty_o
`endif
);

  localparam int NumIds = 2**IdWidth;
  localparam int PtrW = $clog2(Capacity);
  localparam int CrW = $clog2(MaxCredit+1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CrW-1:0] cred_t;
  typedef logic [IdWidth-1:0] id_t;

  localparam ptr_t PtrOne = ptr_t'(1);
  localparam cred_t CrOne = cred_t'(1);
  localparam cred_t CrMax = cred_t'(MaxCredit);

  logic [StructWidth-1:0] mem [Capacity];
  ptr_t next_ptr [Capacity];
  ptr_t free_q [Capacity];
  ptr_t free_rd, free_wr;
  logic free_empty;

  ptr_t head [NumIds];
  ptr_t tail [NumIds];
  logic [NumIds-1:0] nonempty;
  cred_t credit [NumIds];
  id_t last_id;

  logic out_valid_q;
  logic [StructWidth-1:0] data_q;

  logic push, pop, can_load;
  id_t push_id, pop_id;
  ptr_t push_slot, pop_slot;
  logic [NumIds-1:0] eligible, grant;

  assign push = in_valid_i && !free_empty;
  assign push_id = data_i[IdWidth-1:0];
  assign push_slot = free_q[free_rd];
  assign can_load = !out_valid_q || out_ready_i;
  assign pop = |grant;
  assign pop_slot = head[pop_id];

  assign in_ready_o = !free_empty;
  assign out_valid_o = out_valid_q;
  assign data_o = data_q;

  // an ID may be served when it holds data and credit
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumIds; i++)
      eligible[i] = nonempty[i] && (credit[i] != '0);
  end

  simmem_rr_arbiter #(
    .NumIds(NumIds)
  ) u_arb (
    .req     (eligible),
    .last_id (last_id),
    .advance (can_load),
    .grant   (grant),
    .grant_id(pop_id)
  );

  // free list: ring of slot indices; rd==wr means full unless empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Capacity; i++)
        free_q[i] <= ptr_t'(i);
      free_rd <= '0;
      free_wr <= '0;
      free_empty <= 1'b0;
    end else begin
      if (push) free_rd <= free_rd + PtrOne;
      if (pop) begin
        free_q[free_wr] <= pop_slot;
        free_wr <= free_wr + PtrOne;
      end
      if (push && !pop)
        free_empty <= ((free_rd + PtrOne) == free_wr);
      else if (pop && !push)
        free_empty <= 1'b0;
    end
  end

  // per-ID head/tail; a push onto a queue being emptied restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
      end
      nonempty <= '0;
      last_id <= '1;
    end else begin
      if (pop) begin
        last_id <= pop_id;
        if (head[pop_id] == tail[pop_id])
          nonempty[pop_id] <= 1'b0;
        else
          head[pop_id] <= next_ptr[pop_slot];
      end
      if (push) begin
        if (!nonempty[push_id] ||
            (pop && pop_id == push_id &&
             head[push_id] == tail[push_id])) begin
          head[push_id] <= push_slot;
          tail[push_id] <= push_slot;
          nonempty[push_id] <= 1'b1;
        end else begin
          tail[push_id] <= push_slot;
        end
      end
    end
  end

  // payload RAM and link array need no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[push_slot] <= data_i;
      if (nonempty[push_id])
        next_ptr[tail[push_id]] <= push_slot;
    end
  end

  // saturating credits; release and pop together cancel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++)
        credit[i] <= '0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        if (release_valid_i && release_id_i == id_t'(i) &&
            !(pop && pop_id == id_t'(i))) begin
          if (credit[i] != CrMax)
            credit[i] <= credit[i] + CrOne;
        end else if (pop && pop_id == id_t'(i) &&
                     !(release_valid_i &&
                       release_id_i == id_t'(i))) begin
          credit[i] <= credit[i] - CrOne;
        end
      end
    end
  end

  // output register reloads on the cycle it is empty or handed off
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      data_q <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      data_q <= mem[pop_slot];
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef SIMMEM_MSG_BANK_OCCUPANCY_EN
  logic [$clog2(Capacity+1)-1:0] free_cnt;

  // free-slot count mirrors the free list
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      free_cnt <= ($clog2(Capacity+1))'(Capacity);
    else if (push && !pop)
      free_cnt <= free_cnt - 1'b1;
    else if (pop && !push)
      free_cnt <= free_cnt + 1'b1;
  end

  assign free_slots_o = free_cnt;
  assign id_nonempty_o = nonempty;
`else
  // no occupancy observation in this build
`endif

endmodule

// File: doc/simmem_id_message_bank.md
SIMMEM_ID_MESSAGE_BANK -- requirements
Module: simmem_id_message_bank

Interface
REQ-001 SHALL have parameter StructWidth, default 64: message width in bits; the ID field is data_i[IdWidth-1:0].
REQ-002 SHALL have parameter IdWidth, default 4: ID field width; NumIds = 2**IdWidth.
REQ-003 SHALL have parameter Capacity, default 32: total message slots shared by all IDs; must be a power of two and at least 2.
REQ-004 SHALL have parameter MaxCredit, default Capacity: per-ID release-credit saturation value.
REQ-005 SHALL have ports clk_i (in, 1) as the clock and rst_i (in, 1) as the reset; reset is asynchronous and active-high.
REQ-006 SHALL have ports in_valid_i (in, 1), in_ready_o (out, 1) and data_i (in, StructWidth): message ingress handshake and payload.
REQ-007 SHALL have ports release_valid_i (in, 1) and release_id_i (in, IdWidth): grants one release credit to the given ID.
REQ-008 SHALL have ports out_valid_o (out, 1), out_ready_i (in, 1) and data_o (out, StructWidth): released-message egress.

Function
REQ-009 SHALL store messages in one shared RAM of Capacity slots, with a next-pointer array and a free list, forming one FIFO linked list per ID.
REQ-010 SHALL drive in_ready_o high iff the free list is non-empty.
- It is not a function of in_valid_i.
- A slot freed by a pop in cycle T counts as free from T+1.
REQ-011 SHALL, on an in_valid_i && in_ready_o handshake, append data_i to the tail of queue data_i[IdWidth-1:0]; an append to an empty queue sets both head and tail.
REQ-012 SHALL keep one credit counter per ID.
- release_valid_i increments credit[release_id_i].
- The counter saturates at MaxCredit.
- Credit may accumulate while the queue is empty.
REQ-013 SHALL treat an ID as eligible iff its queue is non-empty and its credit is greater than 0.
REQ-014 SHALL select among eligible IDs round-robin: start from the ID after the last served ID, wrapping NumIds-1 to 0.
REQ-015 SHALL hold a single output register. When the register is empty, or is handed off (out_valid_o && out_ready_i) in that cycle, and an eligible ID exists, it SHALL in the same cycle:
- pop that ID's head;
- decrement its credit;
- return the slot to the free list;
- load the register, so out_valid_o is high the next cycle.
REQ-016 SHALL give a latency from an ingress handshake in cycle T to out_valid_o of at least T+2, reached when credit is already present and no other ID is eligible.
REQ-017 SHALL keep data_o stable and out_valid_o high until out_ready_i; back-to-back releases sustain one message per cycle.
REQ-018 SHALL give correct results for these simultaneous events:
- Push and pop on the same single-element ID: the queue is left holding exactly the new message.
- Release and pop on the same ID: the credit is unchanged.
- Push when full: it is not accepted.
REQ-019 SHALL preserve per-ID order; no ordering is guaranteed across IDs.

Reset
REQ-020 SHALL, while rst_i is high, reset asynchronously:
- out_valid_o = 0 and data_o = 0;
- all credits = 0;
- all queues empty;
- free list = all slots;
- round-robin pointer = NumIds-1 (so ID 0 wins first);
- in_ready_o = 1 from the first cycle after deassertion.
REQ-021 SHALL discard any in-flight or stored messages and credits when rst_i is asserted mid-operation.

Configuration
REQ-022 SHALL, with SIMMEM_MSG_BANK_OCCUPANCY_EN defined:
- add output free_slots_o, width $clog2(Capacity+1), which equals the current free-list count and resets to Capacity;
- add output id_nonempty_o, width NumIds, which has one bit per ID and resets to all zeros.
REQ-023 SHALL omit these ports and their counters entirely when SIMMEM_MSG_BANK_OCCUPANCY_EN is undefined; core behaviour is identical either way.

Structure
REQ-024 SHALL place the slot-pointer and credit typedefs and the StructWidth/IdWidth defaults in simmem_pkg.
REQ-025 SHALL implement the round-robin arbiter as sub-module simmem_rr_arbiter, parameterised by NumIds, with inputs req, the last-served ID and an advance enable, and outputs grant and grant_id.

Verification
REQ-026 SHALL cover single-message latency: push ID 3 with payload 0xA5 at T with credit[3]=1 already present -> out_valid_o at T+2 with data_o=0xA5, then credit[3]=0.
REQ-027 SHALL cover per-ID order: push ID 2 with 0x11, 0x22, 0x33, then release ID 2 three times -> outputs 0x11, 0x22, 0x33 in order.
REQ-028 SHALL cover round-robin: IDs 0, 1 and 5 each hold 2 messages with 2 credits, and out_ready_i is held high -> service order is 0, 1, 5, 0, 1, 5.
REQ-029 SHALL cover full and back-pressure: Capacity=32 with 32 pushes and no credit -> in_ready_o=0; one release plus a pop -> in_ready_o=1 the cycle after the pop.
REQ-030 SHALL cover credit saturation: MaxCredit+3 releases to ID 7, then MaxCredit+3 pushes to ID 7 -> exactly MaxCredit messages output.
REQ-031 SHALL cover reset mid-stream: assert rst_i while out_valid_o=1 -> out_valid_o=0 immediately, and free_slots_o=Capacity when SIMMEM_MSG_BANK_OCCUPANCY_EN is defined.
